io_bank_ctrl: RTL and testbench

- Parametrised successor to the fixed 10-pin user-design IO wrapper.
- Sits between the fabric user design (`io_in`/`io_out`/`io_oeb`) and N bidirectional IO cells.
- Adds per-channel input synchronisation, rise/fall event pulses, and optional output registering.
- Adds a built-in loopback self-test (BIST) that walks a 1/0 pattern across all pads and reports per-channel failures.

---
 rtl/io_bank_pkg.sv | 24 ++
 rtl/io_sync_edge.sv | 45 ++++
 rtl/io_bank_ctrl.sv | 165 ++++++++++++++++
 tb/tb_io_bank_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// Shared types and constants for the parametrised IO bank controller.
package io_bank_pkg;

    typedef enum logic [2:0] {
        BIST_IDLE,
        BIST_DRIVE,
        BIST_SETTLE,
        BIST_CHECK,
        BIST_DONE
    } bist_state_t;

    // Phase 1 drives a walking one, phase 0 drives a walking zero
    localparam logic PHASE_HIGH = 1'b1;
    localparam logic PHASE_LOW  = 1'b0;

    // Wide enough for SYNC_STAGES up to 4
    localparam int SETTLE_CNT_W = 3;

    // Channel index width, never narrower than one bit so N_IO=1 still works
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// One channel of input synchronisation with rise/fall detection.
// While frozen the user-facing level holds its last value and no edges are reported,
// but the synchroniser chain keeps running so the self-test can observe the pad.
module io_sync_edge
    import io_bank_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic freeze,
    input  logic pad_in,
    output logic sync_last,
    output logic usr_in,
    output logic in_rise,
    output logic in_fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   held;

    // Shift the raw pad level through the synchroniser stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pad_in};
        end
    end

    // One-cycle-delayed copy for edge detection; it stops updating while frozen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
        end else if (!freeze) begin
            held <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_last = chain[SYNC_STAGES-1];
    assign usr_in    = freeze ? held : sync_last;
    assign in_rise   = ~freeze &  sync_last & ~held;
    assign in_fall   = ~freeze & ~sync_last &  held;

endmodule

// File: rtl/io_bank_ctrl.sv
// IO bank controller: user-design to pad muxing, optional output registering,
// per-channel input synchronisers and a walking-one/zero loopback self-test.
module io_bank_ctrl
    import io_bank_pkg::*;
#(
    parameter int              N_IO         = 10,
    parameter int              SYNC_STAGES  = 2,
    parameter logic [N_IO-1:0] OUT_REG_MASK = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IO-1:0] usr_out,
    input  logic [N_IO-1:0] usr_oeb,
    output logic [N_IO-1:0] usr_in,
    output logic [N_IO-1:0] in_rise,
    output logic [N_IO-1:0] in_fall,
    input  logic [N_IO-1:0] pad_in,
    output logic [N_IO-1:0] pad_out,
    output logic [N_IO-1:0] pad_oeb,
    input  logic            bist_start,
    output logic            bist_busy,
    output logic            bist_done,
    output logic            bist_fail,
    output logic [N_IO-1:0] bist_fail_mask
);

    localparam int                       IDX_W       = idx_width(N_IO);
    localparam logic [IDX_W-1:0]         LAST_IDX    = IDX_W'(N_IO - 1);
    localparam logic [SETTLE_CNT_W-1:0]  SETTLE_LAST = SETTLE_CNT_W'(SYNC_STAGES - 1);

    bist_state_t             state, state_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic                    phase, phase_next;
    logic [SETTLE_CNT_W-1:0] cnt, cnt_next;
    logic [N_IO-1:0]         fail_mask, fail_mask_next;
    logic [N_IO-1:0]         drive_vec, drive_vec_next;
    logic [N_IO-1:0]         out_q, oeb_q;
    logic                    pass_en;
    logic [N_IO-1:0]         sync_last;
    logic                    busy;
    logic                    bist_drive;
    logic [N_IO-1:0]         user_out, user_oeb;

    // Test vector: the selected channel carries the phase, every other channel its inverse
    function automatic logic [N_IO-1:0] pattern(input logic [IDX_W-1:0] i, input logic ph);
        logic [N_IO-1:0] one_hot;
        one_hot = N_IO'(1) << i;
        return ph ? one_hot : ~one_hot;
    endfunction

    for (genvar i = 0; i < N_IO; i++) begin : g_chan
        io_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .freeze    (busy),
            .pad_in    (pad_in[i]),
            .sync_last (sync_last[i]),
            .usr_in    (usr_in[i]),
            .in_rise   (in_rise[i]),
            .in_fall   (in_fall[i])
        );
    end

    // Self-test sequencing: walk each channel through a high and a low phase
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        phase_next     = phase;
        cnt_next       = cnt;
        fail_mask_next = fail_mask;
        unique case (state)
            BIST_IDLE: begin
                if (bist_start) begin
                    state_next     = BIST_DRIVE;
                    idx_next       = '0;
                    phase_next     = PHASE_HIGH;
                    fail_mask_next = '0;
                end
            end
            BIST_DRIVE: begin
                state_next = BIST_SETTLE;
                cnt_next   = '0;
            end
            BIST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = BIST_CHECK;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            BIST_CHECK: begin
                fail_mask_next = fail_mask | (sync_last ^ drive_vec);
                if (phase == PHASE_HIGH) begin
                    phase_next = PHASE_LOW;
                    state_next = BIST_DRIVE;
                end else if (idx < LAST_IDX) begin
                    idx_next   = idx + 1'b1;
                    phase_next = PHASE_HIGH;
                    state_next = BIST_DRIVE;
                end else begin
                    state_next = BIST_DONE;
                end
            end
            BIST_DONE: begin
                state_next = BIST_IDLE;
            end
            default: begin
                state_next = BIST_IDLE;
            end
        endcase
    end

    assign drive_vec_next = pattern(idx_next, phase_next);

    // Self-test state, counters, sticky failure flags and the registered drive vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BIST_IDLE;
            idx       <= '0;
            phase     <= PHASE_HIGH;
            cnt       <= '0;
            fail_mask <= '0;
            drive_vec <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            phase     <= phase_next;
            cnt       <= cnt_next;
            fail_mask <= fail_mask_next;
            drive_vec <= drive_vec_next;
        end
    end

    // Registered copy of the user outputs; pass_en keeps bypass channels tristated until reset is released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            oeb_q   <= '1;
            pass_en <= 1'b0;
        end else begin
            out_q   <= usr_out;
            oeb_q   <= usr_oeb;
            pass_en <= 1'b1;
        end
    end

    assign busy       = (state == BIST_DRIVE) || (state == BIST_SETTLE) || (state == BIST_CHECK);
    assign bist_drive = (state != BIST_IDLE);

    // Pad muxing: the self-test owns every pad until the cycle after DONE
    always_comb begin
        user_out = (out_q & OUT_REG_MASK) | (usr_out & ~OUT_REG_MASK & {N_IO{pass_en}});
        user_oeb = (oeb_q & OUT_REG_MASK) | (~OUT_REG_MASK & (pass_en ? usr_oeb : '1));
        pad_out  = bist_drive ? drive_vec : user_out;
        pad_oeb  = bist_drive ? '0 : user_oeb;
    end

    assign bist_busy      = busy;
    assign bist_done      = (state == BIST_DONE);
    assign bist_fail      = ~busy & (|fail_mask);
    assign bist_fail_mask = fail_mask;

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Scoreboard bench for io_bank_ctrl (N_IO=10, SYNC_STAGES=2, OUT_REG_MASK=0x3F0).
module tb_io_bank_ctrl;

    typedef enum int {SIG_USR_IN, SIG_RISE, SIG_FALL, SIG_EDGES, SIG_PAD_OUT, SIG_PAD_OEB,
                      SIG_BUSY, SIG_DONE, SIG_FAIL, SIG_MASK} sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] value;
        string       name;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       fail;
        logic [9:0] mask;
    } done_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] usr_out, usr_oeb, usr_in, in_rise, in_fall;
    logic [9:0] pad_in, pad_out, pad_oeb;
    logic       bist_start, bist_busy, bist_done, bist_fail;
    logic [9:0] bist_fail_mask;

    logic [9:0] ext_in;
    logic       loop_en;
    logic [9:0] stuck0;
    logic       short_en;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  exp_q[$];
    done_t done_q[$];

    io_bank_ctrl #(
        .N_IO         (10),
        .SYNC_STAGES  (2),
        .OUT_REG_MASK (10'h3F0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .usr_out        (usr_out),
        .usr_oeb        (usr_oeb),
        .usr_in         (usr_in),
        .in_rise        (in_rise),
        .in_fall        (in_fall),
        .pad_in         (pad_in),
        .pad_out        (pad_out),
        .pad_oeb        (pad_oeb),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_mask (bist_fail_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: driven pads loop back, optional stuck-at-0 and a wired-AND short between ch2 and ch3
    always_comb begin : lb_model
        logic [9:0] lb;
        lb = pad_out;
        if (short_en) begin
            lb[2] = pad_out[2] & pad_out[3];
            lb[3] = pad_out[2] & pad_out[3];
        end
        if (loop_en) pad_in = ((~pad_oeb & lb) | (pad_oeb & ext_in)) & ~stuck0;
        else         pad_in = ext_in;
    end

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] getSig(input sig_e s);
        case (s)
            SIG_USR_IN:  return {22'd0, usr_in};
            SIG_RISE:    return {22'd0, in_rise};
            SIG_FALL:    return {22'd0, in_fall};
            SIG_EDGES:   return {22'd0, in_rise | in_fall};
            SIG_PAD_OUT: return {22'd0, pad_out};
            SIG_PAD_OEB: return {22'd0, pad_oeb};
            SIG_BUSY:    return {31'd0, bist_busy};
            SIG_DONE:    return {31'd0, bist_done};
            SIG_FAIL:    return {31'd0, bist_fail};
            SIG_MASK:    return {22'd0, bist_fail_mask};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        compareVal(e.name, getSig(e.sig), e.value);
    endtask

    // Queue an expectation for a given cycle, keeping the queue sorted by cycle
    task automatic expectAt(input int c, input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        int   pos;
        e.cyc = c; e.sig = s; e.value = v; e.name = n;
        pos = exp_q.size();
        while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
        exp_q.insert(pos, e);
    endtask

    task automatic expectDone(input int c, input logic f, input logic [9:0] m);
        done_t d;
        d.cyc = c; d.fail = f; d.mask = m;
        done_q.push_back(d);
    endtask

    task automatic waitCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int c, input logic [9:0] o, input logic [9:0] oe, input logic [9:0] ext);
        waitCycle(c);
        usr_out = o;
        usr_oeb = oe;
        ext_in  = ext;
    endtask

    // Monitor: timed expectations checked on the falling edge, BIST results checked when done pulses
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checkOutput(exp_q.pop_front());
        end
        if (bist_done) begin
            if (done_q.size() == 0) begin
                compareVal("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                compareVal("done_cycle", cyc, d.cyc);
                compareVal("done_fail", {31'd0, bist_fail}, {31'd0, d.fail});
                compareVal("done_mask", {22'd0, bist_fail_mask}, {22'd0, d.mask});
            end
        end
    end

    initial begin
        int s;
        rst_n = 1'b0; ext_in = 10'h3FF; usr_out = '0; usr_oeb = 10'h3FF;
        bist_start = 1'b0; loop_en = 1'b0; stuck0 = '0; short_en = 1'b0;

        // Reset with all pads high
        for (int c = 1; c <= 3; c++) begin
            expectAt(c, SIG_PAD_OEB, 32'h3FF, "rst_pad_oeb");
            expectAt(c, SIG_PAD_OUT, 32'h000, "rst_pad_out");
            expectAt(c, SIG_USR_IN,  32'h000, "rst_usr_in");
            expectAt(c, SIG_EDGES,   32'h000, "rst_edges");
            expectAt(c, SIG_BUSY,    32'h0,   "rst_busy");
            expectAt(c, SIG_MASK,    32'h000, "rst_mask");
        end
        waitCycle(3);
        rst_n  = 1'b1;
        ext_in = '0;

        // Input synchroniser latency and edge pulses
        expectAt(7,  SIG_USR_IN, 32'h000, "sync_before");
        expectAt(8,  SIG_USR_IN, 32'h155, "sync_after");
        expectAt(8,  SIG_RISE,   32'h155, "rise_pulse");
        expectAt(8,  SIG_FALL,   32'h000, "rise_nofall");
        expectAt(9,  SIG_RISE,   32'h000, "rise_end");
        expectAt(11, SIG_USR_IN, 32'h155, "fall_before");
        expectAt(12, SIG_USR_IN, 32'h000, "fall_after");
        expectAt(12, SIG_FALL,   32'h155, "fall_pulse");
        expectAt(12, SIG_RISE,   32'h000, "fall_norise");
        expectAt(13, SIG_FALL,   32'h000, "fall_end");
        applyStimulus(6,  10'h000, 10'h3FF, 10'h155);
        applyStimulus(10, 10'h000, 10'h3FF, 10'h000);

        // Output registering: low nibble bypassed, upper six channels registered
        expectAt(20, SIG_PAD_OUT, 32'h00F, "oreg_out_c0");
        expectAt(20, SIG_PAD_OEB, 32'h3F0, "oreg_oeb_c0");
        expectAt(21, SIG_PAD_OUT, 32'h3FF, "oreg_out_c1");
        expectAt(21, SIG_PAD_OEB, 32'h000, "oreg_oeb_c1");
        expectAt(22, SIG_PAD_OUT, 32'h3F5, "oreg_out2_c0");
        expectAt(23, SIG_PAD_OUT, 32'h0A5, "oreg_out2_c1");
        applyStimulus(20, 10'h3FF, 10'h000, 10'h000);
        applyStimulus(22, 10'h0A5, 10'h000, 10'h000);

        // BIST with a clean loopback
        applyStimulus(30, 10'h123, 10'h000, 10'h000);
        loop_en = 1'b1;
        s = 40;
        expectAt(s,      SIG_USR_IN,  32'h123, "pre_bist_usr_in");
        expectAt(s,      SIG_BUSY,    32'h0,   "bist_idle_busy");
        expectAt(s + 1,  SIG_BUSY,    32'h1,   "bist_busy_start");
        expectAt(s + 1,  SIG_PAD_OUT, 32'h001, "bist_drive_walk1");
        expectAt(s + 1,  SIG_PAD_OEB, 32'h000, "bist_drive_oeb");
        expectAt(s + 5,  SIG_PAD_OUT, 32'h3FE, "bist_drive_walk0");
        for (int c = s + 2; c <= s + 12; c++) expectAt(c, SIG_EDGES, 32'h0, "frozen_edges");
        expectAt(s + 10, SIG_USR_IN,  32'h123, "frozen_usr_in");
        expectAt(s + 80, SIG_BUSY,    32'h1,   "bist_busy_last");
        expectAt(s + 80, SIG_DONE,    32'h0,   "bist_done_early");
        expectAt(s + 81, SIG_BUSY,    32'h0,   "bist_busy_end");
        expectAt(s + 81, SIG_PAD_OUT, 32'h1FF, "bist_done_drive");
        expectAt(s + 82, SIG_DONE,    32'h0,   "bist_done_width");
        expectAt(s + 82, SIG_PAD_OUT, 32'h123, "revert_pad_out");
        expectAt(s + 82, SIG_PAD_OEB, 32'h000, "revert_pad_oeb");
        expectDone(s + 81, 1'b0, 10'h000);
        waitCycle(s);
        bist_start = 1'b1;
        waitCycle(s + 1);
        bist_start = 1'b0;

        // BIST with channel 6 stuck low
        waitCycle(125);
        stuck0 = 10'h040;
        s = 130;
        expectAt(s + 85, SIG_FAIL, 32'h1,   "stuck_fail_hold");
        expectAt(s + 85, SIG_MASK, 32'h040, "stuck_mask_hold");
        expectDone(s + 81, 1'b1, 10'h040);
        waitCycle(s);
        bist_start = 1'b1;
        waitCycle(s + 1);
        bist_start = 1'b0;

        // BIST with channels 2 and 3 shorted; start must clear the old mask
        waitCycle(215);
        stuck0   = '0;
        short_en = 1'b1;
        s = 220;
        expectAt(s,     SIG_FAIL, 32'h1,   "old_fail_held");
        expectAt(s,     SIG_MASK, 32'h040, "old_mask_held");
        expectAt(s + 1, SIG_MASK, 32'h000, "mask_cleared");
        expectAt(s + 1, SIG_FAIL, 32'h0,   "fail_cleared");
        expectDone(s + 81, 1'b1, 10'h00C);
        waitCycle(s);
        bist_start = 1'b1;
        waitCycle(s + 1);
        bist_start = 1'b0;

        // Reset in the middle of a run
        waitCycle(305);
        short_en = 1'b0;
        stuck0   = 10'h001;
        s = 310;
        expectAt(s + 30, SIG_BUSY,    32'h1,   "midrst_busy_before");
        expectAt(s + 30, SIG_MASK,    32'h001, "midrst_mask_before");
        expectAt(s + 31, SIG_BUSY,    32'h0,   "midrst_busy");
        expectAt(s + 31, SIG_MASK,    32'h000, "midrst_mask");
        expectAt(s + 31, SIG_PAD_OEB, 32'h3FF, "midrst_pad_oeb");
        expectAt(s + 31, SIG_PAD_OUT, 32'h000, "midrst_pad_out");
        expectAt(s + 32, SIG_PAD_OUT, 32'h123, "midrst_user_back");
        waitCycle(s);
        bist_start = 1'b1;
        waitCycle(s + 1);
        bist_start = 1'b0;
        waitCycle(s + 30);
        rst_n = 1'b0;
        waitCycle(s + 31);
        rst_n  = 1'b1;
        stuck0 = '0;

        // Retrigger while busy and start during DONE are both ignored
        s = 360;
        expectAt(s + 22, SIG_BUSY, 32'h1, "retrig_busy");
        expectAt(s + 80, SIG_BUSY, 32'h1, "retrig_busy_last");
        expectAt(s + 80, SIG_DONE, 32'h0, "retrig_done_early");
        expectAt(s + 81, SIG_BUSY, 32'h0, "retrig_busy_end");
        expectAt(s + 82, SIG_BUSY, 32'h0, "done_start_ignored");
        expectAt(s + 83, SIG_BUSY, 32'h0, "done_start_ignored2");
        expectAt(s + 83, SIG_DONE, 32'h0, "done_no_repeat");
        expectDone(s + 81, 1'b0, 10'h000);
        waitCycle(s);
        bist_start = 1'b1;
        waitCycle(s + 1);
        bist_start = 1'b0;
        waitCycle(s + 20);
        bist_start = 1'b1;
        waitCycle(s + 21);
        bist_start = 1'b0;
        waitCycle(s + 81);
        bist_start = 1'b1;
        waitCycle(s + 82);
        bist_start = 1'b0;

        waitCycle(s + 95);
        compareVal("pending_expectations", exp_q.size(), 32'd0);
        compareVal("pending_done_events", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
